// File: rtl/usart_pkg.sv
// usart_pkg: types and constants shared by the usart transmit and receive stages
package usart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} usart_tx_state_t;
    localparam int USART_DATA_BITS = 8;
    localparam logic USART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/usart_baud_counter.sv
// usart_baud_counter: bit-period divider producing a one-cycle tick every mult*CLOCKS_PER_BIT cycles
//   comm_clock, reset : clock and synchronous active-high reset
//   clear             : holds the count at zero so the next period starts aligned
//   mult              : number of bit periods per tick (up to MAX_MULT)
//   tick              : high on the last cycle of each period
module usart_baud_counter #(
    parameter int CLOCKS_PER_BIT = 104,
    parameter int MAX_MULT = 2
) (
    input  logic       comm_clock,
    input  logic       reset,
    input  logic       clear,
    input  logic [1:0] mult,
    output logic       tick
);
    localparam int W = $clog2(CLOCKS_PER_BIT * MAX_MULT);
    logic [W-1:0] count;
    logic [W-1:0] term;
    assign term = W'(CLOCKS_PER_BIT * int'(mult) - 1);
    assign tick = count == term;
    always_ff @(posedge comm_clock)
        count <= (reset || clear || tick) ? '0 : count + 1'b1;
endmodule

// File: rtl/usart_tx.sv
// usart_tx: pulls bytes from the transmit FIFO and sends them as 8N1/8N2 frames on tx
//   comm_clock, reset : clock and synchronous active-high reset
//   fifo_ready        : byte request to the FIFO (out_ready)
//   fifo_valid        : one-cycle pulse qualifying fifo_data (out_valid)
//   fifo_data         : byte from the FIFO
//   tx                : serial line, idles high
//   busy              : high from start bit through the last stop bit
module usart_tx
    import usart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 104,
    parameter int STOP_BITS = 1
) (
    input  logic       comm_clock,
    input  logic       reset,
    output logic       fifo_ready,
    input  logic       fifo_valid,
    input  logic [7:0] fifo_data,
    output logic       tx,
    output logic       busy
);
    usart_tx_state_t state, state_n;
    logic [USART_DATA_BITS-1:0] shreg, shreg_n;
    logic [2:0] idx, idx_n;
    logic tx_n, busy_n, ready_n, tick;
    logic last_bit;

    // The counter sits at zero through IDLE so the start bit gets a full period.
    usart_baud_counter #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT),
        .MAX_MULT(STOP_BITS)
    ) u_baud (
        .comm_clock(comm_clock),
        .reset(reset),
        .clear(state == IDLE),
        .mult(state == STOP ? 2'(STOP_BITS) : 2'd1),
        .tick(tick)
    );

    assign last_bit = idx == 3'(USART_DATA_BITS - 1);

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n = idx;
        tx_n = tx;
        busy_n = busy;
        ready_n = fifo_ready;
        case (state)
            IDLE: begin
                // Dropping ready on the capture edge limits the FIFO to one read per request.
                ready_n = !(fifo_ready && fifo_valid);
                if (fifo_ready && fifo_valid) begin
                    shreg_n = fifo_data;
                    tx_n = 1'b0;
                    busy_n = 1'b1;
                    state_n = START;
                end
            end
            START: if (tick) begin
                state_n = DATA;
                idx_n = '0;
                tx_n = shreg[0];
            end
            DATA: if (tick) begin
                // tx is registered, so it is loaded with the bit that follows the one on the line.
                shreg_n = shreg >> 1;
                idx_n = idx + 3'd1;
                tx_n = last_bit ? USART_IDLE_LEVEL : shreg[1];
                state_n = last_bit ? STOP : DATA;
            end
            STOP: if (tick) begin
                state_n = IDLE;
                busy_n = 1'b0;
                ready_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge comm_clock) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            idx <= '0;
            tx <= USART_IDLE_LEVEL;
            busy <= 1'b0;
            fifo_ready <= 1'b0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            idx <= idx_n;
            tx <= tx_n;
            busy <= busy_n;
            fifo_ready <= ready_n;
        end
    end
endmodule

// File: tb/tb_usart_tx.sv
// tb_usart_tx: directed checks of usart_tx with FIFO models, 4 clocks per bit, 1 and 2 stop bits
module tb_usart_tx;
    logic comm_clock = 1'b0;
    always #5 comm_clock = ~comm_clock;
    logic reset = 1'b1;

    logic r1, v1, tx1, b1;
    logic v1m = 1'b0, inj1 = 1'b0;
    logic [7:0] d1, d1m = 8'h00, inj_data = 8'h00;
    logic r2, tx2, b2;
    logic v2 = 1'b0;
    logic [7:0] d2 = 8'h00;
    logic [7:0] q1[$], q2[$];
    int reads1 = 0, reads2 = 0, stray1 = 0;
    int passed = 0, total = 0;

    assign v1 = v1m | inj1;
    assign d1 = inj1 ? inj_data : d1m;

    usart_tx #(.CLOCKS_PER_BIT(4), .STOP_BITS(1)) u_dut1 (
        .comm_clock(comm_clock), .reset(reset), .fifo_ready(r1), .fifo_valid(v1),
        .fifo_data(d1), .tx(tx1), .busy(b1)
    );
    usart_tx #(.CLOCKS_PER_BIT(4), .STOP_BITS(2)) u_dut2 (
        .comm_clock(comm_clock), .reset(reset), .fifo_ready(r2), .fifo_valid(v2),
        .fifo_data(d2), .tx(tx2), .busy(b2)
    );

    // FIFO models: issue a one-cycle valid only when ready && !valid and data is queued.
    always @(posedge comm_clock) begin
        if (v1 && !r1) stray1 <= stray1 + 1;
        v1m <= 1'b0;
        if (r1 && !v1m && q1.size() > 0) begin
            v1m <= 1'b1;
            d1m <= q1.pop_front();
            reads1 <= reads1 + 1;
        end
        v2 <= 1'b0;
        if (r2 && !v2 && q2.size() > 0) begin
            v2 <= 1'b1;
            d2 <= q2.pop_front();
            reads2 <= reads2 + 1;
        end
    end

    task test_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge comm_clock);
            total++;
            if ({tx1, r1, b1, tx2, r2, b2} !== 6'b100100)
                $display("FAIL reset_hold cycle %0d got %b want 100100", i, {tx1, r1, b1, tx2, r2, b2});
            else passed++;
        end
        reset = 1'b0;
        @(negedge comm_clock);
        total++;
        if ({tx1, r1, b1, tx2, r2, b2} !== 6'b110110)
            $display("FAIL reset_release got %b want 110110", {tx1, r1, b1, tx2, r2, b2});
        else passed++;
    endtask

    task test_single_byte;
        int r0, n;
        logic [7:0] b;
        logic e;
        b = 8'hA3;
        r0 = reads1;
        q1.push_back(b);
        n = 0;
        do begin @(negedge comm_clock); n++; end while (tx1 !== 1'b0 && n < 10);
        total++;
        if (tx1 !== 1'b0) $display("FAIL a3_start_timeout got tx=%b want 0", tx1);
        else passed++;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge comm_clock);
            e = i < 4 ? 1'b0 : i < 36 ? b[(i - 4) / 4] : 1'b1;
            total++;
            if ({tx1, b1} !== {e, 1'b1})
                $display("FAIL a3_frame sample %0d got tx,busy=%b want %b", i, {tx1, b1}, {e, 1'b1});
            else passed++;
        end
        @(negedge comm_clock);
        total++;
        if ({tx1, b1} !== 2'b10) $display("FAIL a3_end got tx,busy=%b want 10", {tx1, b1});
        else passed++;
        repeat (4) @(negedge comm_clock);
        total++;
        if (reads1 - r0 !== 1 || r1 !== 1'b1)
            $display("FAIL a3_reads got reads=%0d ready=%b want 1 1", reads1 - r0, r1);
        else passed++;
    endtask

    task test_back_to_back;
        int r0, n, j;
        logic f, e, be;
        logic [7:0] d;
        r0 = reads2;
        q2.push_back(8'h55);
        q2.push_back(8'h00);
        n = 0;
        do begin @(negedge comm_clock); n++; end while (tx2 !== 1'b0 && n < 10);
        total++;
        if (tx2 !== 1'b0) $display("FAIL b2b_start_timeout got tx=%b want 0", tx2);
        else passed++;
        // Frame 1 is 44 cycles plus a 2-cycle gap; frame 2 follows for another 44.
        for (int i = 0; i < 90; i++) begin
            if (i > 0) @(negedge comm_clock);
            f = i >= 46;
            j = f ? i - 46 : i;
            d = f ? 8'h00 : 8'h55;
            e = j < 4 ? 1'b0 : j < 36 ? d[(j - 4) / 4] : 1'b1;
            be = j < 44;
            total++;
            if ({tx2, b2} !== {e, be})
                $display("FAIL b2b_frame sample %0d got tx,busy=%b want %b", i, {tx2, b2}, {e, be});
            else passed++;
        end
        @(negedge comm_clock);
        total++;
        if ({tx2, b2} !== 2'b10) $display("FAIL b2b_end got tx,busy=%b want 10", {tx2, b2});
        else passed++;
        repeat (4) @(negedge comm_clock);
        total++;
        if (reads2 - r0 !== 2) $display("FAIL b2b_reads got %0d want 2", reads2 - r0);
        else passed++;
    endtask

    task test_empty_fifo;
        int r0;
        r0 = reads1;
        for (int i = 0; i < 100; i++) begin
            @(negedge comm_clock);
            total++;
            if ({r1, tx1, b1} !== 3'b110)
                $display("FAIL empty cycle %0d got ready,tx,busy=%b want 110", i, {r1, tx1, b1});
            else passed++;
        end
        total++;
        if (reads1 !== r0) $display("FAIL empty_reads got %0d want %0d", reads1, r0);
        else passed++;
    endtask

    task test_reset_mid_frame;
        int n;
        logic [7:0] b;
        logic e;
        b = 8'h0F;
        q1.push_back(8'hFF);
        q1.push_back(b);
        n = 0;
        do begin @(negedge comm_clock); n++; end while (tx1 !== 1'b0 && n < 10);
        total++;
        if (tx1 !== 1'b0) $display("FAIL midrst_start_timeout got tx=%b want 0", tx1);
        else passed++;
        // Samples 16..19 cover data bit 3.
        repeat (17) @(negedge comm_clock);
        total++;
        if ({tx1, b1} !== 2'b11) $display("FAIL midrst_bit3 got tx,busy=%b want 11", {tx1, b1});
        else passed++;
        reset = 1'b1;
        @(negedge comm_clock);
        total++;
        if ({tx1, b1, r1} !== 3'b100)
            $display("FAIL midrst_reset got tx,busy,ready=%b want 100", {tx1, b1, r1});
        else passed++;
        reset = 1'b0;
        n = 0;
        do begin @(negedge comm_clock); n++; end while (tx1 !== 1'b0 && n < 10);
        total++;
        if (tx1 !== 1'b0) $display("FAIL midrst_next_timeout got tx=%b want 0", tx1);
        else passed++;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge comm_clock);
            e = i < 4 ? 1'b0 : i < 36 ? b[(i - 4) / 4] : 1'b1;
            total++;
            if ({tx1, b1} !== {e, 1'b1})
                $display("FAIL midrst_0f sample %0d got tx,busy=%b want %b", i, {tx1, b1}, {e, 1'b1});
            else passed++;
        end
        @(negedge comm_clock);
        total++;
        if ({tx1, b1} !== 2'b10) $display("FAIL midrst_end got tx,busy=%b want 10", {tx1, b1});
        else passed++;
    endtask

    task test_stray_valid;
        int n, s0, r0;
        logic [7:0] b;
        logic e;
        b = 8'h3C;
        s0 = stray1;
        r0 = reads1;
        q1.push_back(b);
        n = 0;
        do begin @(negedge comm_clock); n++; end while (tx1 !== 1'b0 && n < 10);
        total++;
        if (tx1 !== 1'b0) $display("FAIL stray_start_timeout got tx=%b want 0", tx1);
        else passed++;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge comm_clock);
            e = i < 4 ? 1'b0 : i < 36 ? b[(i - 4) / 4] : 1'b1;
            total++;
            if ({tx1, b1} !== {e, 1'b1})
                $display("FAIL stray_frame sample %0d got tx,busy=%b want %b", i, {tx1, b1}, {e, 1'b1});
            else passed++;
            inj_data = 8'hAA;
            inj1 = i == 10;
        end
        @(negedge comm_clock);
        total++;
        if ({tx1, b1} !== 2'b10) $display("FAIL stray_end got tx,busy=%b want 10", {tx1, b1});
        else passed++;
        repeat (4) @(negedge comm_clock);
        total++;
        if (stray1 - s0 !== 1 || reads1 - r0 !== 1 || tx1 !== 1'b1)
            $display("FAIL stray_flagged got stray=%0d reads=%0d tx=%b want 1 1 1", stray1 - s0, reads1 - r0, tx1);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_empty_fifo;
        test_reset_mid_frame;
        test_stray_valid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
